// File: rtl/alu_pipe_pkg.sv
// Shared names for the pipelined ALU: operation codes and controller states.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_ADD   = 4'd2,
    OP_XOR   = 4'd3,
    OP_LSL   = 4'd4,
    OP_LSR   = 4'd5,
    OP_SUB   = 4'd6,
    OP_PASSB = 4'd7,
    OP_ASR   = 4'd8,
    OP_MUL   = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles
// per operation, low WIDTH bits of the product only.
module alu_mul_iter #(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic             r_busy;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_next;

  // The final iteration's sum is presented combinationally so the owner can
  // capture it on the same edge that ends the multiply.
  assign w_acc_next = r_b[0] ? (r_acc + r_a) : r_acc;
  assign done       = r_busy && (r_count == CW'(WIDTH - 1));
  assign product    = w_acc_next;
  assign busy       = r_busy;

  // Iteration control: busy flag and iteration counter
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_busy  <= 1'b0;
      r_count <= '0;
    end else if (start) begin
      r_busy  <= 1'b1;
      r_count <= '0;
    end else if (r_busy) begin
      if (done) begin
        r_busy <= 1'b0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Operand latch and shift-add datapath
  always_ff @(posedge CLK) begin
    if (start) begin
      r_a   <= A;
      r_b   <= B;
      r_acc <= '0;
    end else if (r_busy) begin
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_acc <= w_acc_next;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides. Single-cycle ops
// complete on the accept edge; MUL runs through the iterative multiplier.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int MUL_EN = 1
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [3:0]       ALUCtrl,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             Busy
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       r_state;
  alu_state_e       w_state_next;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_start;
  logic             w_load_alu;
  logic             w_load_mul;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_prod;

  logic [WIDTH-1:0] r_busw;
  logic             r_zero;
  logic             r_neg;
  logic             r_carry;
  logic             r_ovf;

  assign w_is_mul    = (MUL_EN != 0) && (ALUCtrl == OP_MUL);
  assign w_mul_start = w_accept && w_is_mul;
  assign w_load_alu  = w_accept && !w_is_mul;
  assign w_load_mul  = (r_state == ST_MUL) && w_mul_done;

  // Only the low SHW bits of B form the shift amount.
  assign w_sh   = BusB[SHW-1:0];
  assign w_sum  = {1'b0, BusA} + {1'b0, BusB};
  assign w_diff = {1'b0, BusA} - {1'b0, BusB};

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .start   (w_mul_start),
        .A       (BusA),
        .B       (BusB),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_mul_prod)
      );
    end else begin : g_no_mul
      assign w_mul_busy = 1'b0;
      assign w_mul_done = 1'b0;
      assign w_mul_prod = '0;
    end
  endgenerate

  // Single-cycle op mux with carry/overflow; illegal codes and MUL give zero here
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (ALUCtrl)
      OP_AND:   w_res = BusA & BusB;
      OP_OR:    w_res = BusA | BusB;
      OP_XOR:   w_res = BusA ^ BusB;
      OP_PASSB: w_res = BusB;
      OP_LSL:   w_res = BusA << w_sh;
      OP_LSR:   w_res = BusA >> w_sh;
      OP_ASR:   w_res = $signed(BusA) >>> w_sh;
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (BusA[WIDTH-1] == BusB[WIDTH-1]) && (w_sum[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_SUB: begin
        // Carry means no borrow, i.e. A >= B unsigned.
        w_res = w_diff[WIDTH-1:0];
        w_c   = !w_diff[WIDTH];
        w_v   = (BusA[WIDTH-1] != BusB[WIDTH-1]) && (w_diff[WIDTH-1] != BusA[WIDTH-1]);
      end
      default: w_res = '0;
    endcase
  end

  // Controller state register
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and input-side handshake; DONE passes consumer readiness through
  always_comb begin
    w_state_next = r_state;
    InReady      = 1'b0;
    case (r_state)
      ST_IDLE: InReady = 1'b1;
      ST_DONE: InReady = OutReady;
      default: InReady = 1'b0;
    endcase
    w_accept = InValid && InReady;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = w_is_mul ? ST_MUL : ST_DONE;
        end
      end
      ST_MUL: begin
        if (w_mul_done) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (OutReady) begin
          if (w_accept) begin
            w_state_next = w_is_mul ? ST_MUL : ST_DONE;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Result and flag registers; they hold while the consumer stalls
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_busw  <= '0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load_alu) begin
      r_busw  <= w_res;
      r_zero  <= (w_res == '0);
      r_neg   <= w_res[WIDTH-1];
      r_carry <= w_c;
      r_ovf   <= w_v;
    end else if (w_load_mul) begin
      r_busw  <= w_mul_prod;
      r_zero  <= (w_mul_prod == '0);
      r_neg   <= w_mul_prod[WIDTH-1];
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end
  end

  assign OutValid = (r_state == ST_DONE);
  assign Busy     = w_mul_busy;
  assign BusW     = r_busw;
  assign Zero     = r_zero;
  assign Negative = r_neg;
  assign Carry    = r_carry;
  assign Overflow = r_ovf;

endmodule
